// File: rtl/tcb_full_lib_logsize2byteena_pkg.sv
// -----------------------------------------------------------------------------
// tcb_full_lib_logsize2byteena_pkg
//
// Shared types and helpers for the TCB-Full log-size to byte-enable adapter.
//   tcb_cfg_t      bus/handshake configuration (data/address width, response delay)
//   tcb_dly_t      one response-tracking entry {trn, wen, off, siz, uns}
//   tcb_byt_mask   wrapping byte-enable mask from offset and log2 size
//   tcb_rot_left   rotate byte i to lane (off+i) mod BYT (write data)
//   tcb_rot_right  rotate lane (off+i) mod BYT to byte i (read data)
//
// The helpers operate on a fixed maximum width (TCB_MAX_BYT lanes); the
// active lane count is 2**max, so callers zero-extend their data and keep
// only the low BYT lanes of the result.
// -----------------------------------------------------------------------------
package tcb_full_lib_logsize2byteena_pkg;

   localparam int unsigned TCB_MAX_BYT = 16;
   localparam int unsigned TCB_MAX_DAT = 8 * TCB_MAX_BYT;
   localparam int unsigned TCB_OFF_W   = 4;
   localparam int unsigned TCB_SIZ_W   = 3;

   typedef struct packed {
      int unsigned ADR;
      int unsigned DAT;
   } tcb_bus_cfg_t;

   typedef struct packed {
      int unsigned DLY;
   } tcb_hsk_cfg_t;

   typedef struct packed {
      tcb_bus_cfg_t BUS;
      tcb_hsk_cfg_t HSK;
   } tcb_cfg_t;

   localparam tcb_cfg_t TCB_CFG_DEF = '{BUS: '{ADR: 32, DAT: 32}, HSK: '{DLY: 1}};

   typedef struct packed {
      logic                 trn;
      logic                 wen;
      logic [TCB_OFF_W-1:0] off;
      logic [TCB_SIZ_W-1:0] siz;
      logic                 uns;
   } tcb_dly_t;

   // Lane index mask for a bus of 2**max byte lanes.
   function automatic logic [TCB_OFF_W-1:0] tcb_lane_lim(input int unsigned max);
      return TCB_OFF_W'((32'd1 << max) - 32'd1);
   endfunction

   // An oversized request enables every lane so the access is never silently
   // narrowed; it is flagged by an assertion at the adapter.
   function automatic logic [TCB_MAX_BYT-1:0] tcb_byt_mask(
      input logic [TCB_OFF_W-1:0] off,
      input logic [TCB_SIZ_W-1:0] siz,
      input int unsigned          max
   );
      logic [TCB_MAX_BYT-1:0] msk;
      logic [TCB_OFF_W-1:0]   lim;
      msk = '0;
      lim = tcb_lane_lim(max);
      for (int unsigned i = 0; i < TCB_MAX_BYT; i++) begin
         if (32'(siz) > max) begin
            if (i <= 32'(lim)) msk[TCB_OFF_W'(i)] = 1'b1;
         end else if (i < (32'd1 << siz)) begin
            msk[(off + TCB_OFF_W'(i)) & lim] = 1'b1;
         end
      end
      return msk;
   endfunction

   function automatic logic [TCB_MAX_DAT-1:0] tcb_rot_left(
      input logic [TCB_MAX_DAT-1:0] dat,
      input logic [TCB_OFF_W-1:0]   off,
      input int unsigned            max
   );
      logic [TCB_MAX_DAT-1:0] res;
      logic [TCB_OFF_W-1:0]   lim;
      logic [TCB_OFF_W-1:0]   lane;
      res = '0;
      lim = tcb_lane_lim(max);
      for (int unsigned i = 0; i < TCB_MAX_BYT; i++) begin
         if (i <= 32'(lim)) begin
            lane = (off + TCB_OFF_W'(i)) & lim;
            res[{lane, 3'b000} +: 8] = dat[{TCB_OFF_W'(i), 3'b000} +: 8];
         end
      end
      return res;
   endfunction

   function automatic logic [TCB_MAX_DAT-1:0] tcb_rot_right(
      input logic [TCB_MAX_DAT-1:0] dat,
      input logic [TCB_OFF_W-1:0]   off,
      input int unsigned            max
   );
      logic [TCB_MAX_DAT-1:0] res;
      logic [TCB_OFF_W-1:0]   lim;
      logic [TCB_OFF_W-1:0]   lane;
      res = '0;
      lim = tcb_lane_lim(max);
      for (int unsigned i = 0; i < TCB_MAX_BYT; i++) begin
         if (i <= 32'(lim)) begin
            lane = (off + TCB_OFF_W'(i)) & lim;
            res[{TCB_OFF_W'(i), 3'b000} +: 8] = dat[{lane, 3'b000} +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/tcb_full_lib_logsize2byteena_if.sv
// -----------------------------------------------------------------------------
// tcb_full_lib_logsize2byteena_if
//
// TCB-Full bus bundle. One request struct carries the fields of both modes:
// log-size managers use {siz, uns}, byte-enable subordinates use {byt}.
//   vld/rdy   handshake (transfer when both high)
//   req       {wen, adr, siz, uns, byt, wdt}
//   rsp       {rdt, sts}, fixed latency CFG.HSK.DLY after the transfer
// Modports: man (drives request), sub (drives ready and response).
// -----------------------------------------------------------------------------
interface tcb_full_lib_logsize2byteena_if
   import tcb_full_lib_logsize2byteena_pkg::*;
#(
   parameter type  cfg_t = tcb_cfg_t,
   parameter cfg_t CFG   = TCB_CFG_DEF
) ();

   localparam int unsigned ADR = CFG.BUS.ADR;
   localparam int unsigned DAT = CFG.BUS.DAT;
   localparam int unsigned BYT = DAT / 8;

   typedef struct packed {
      logic                 wen;
      logic [ADR-1:0]       adr;
      logic [TCB_SIZ_W-1:0] siz;
      logic                 uns;
      logic [BYT-1:0]       byt;
      logic [DAT-1:0]       wdt;
   } req_t;

   typedef struct packed {
      logic [DAT-1:0] rdt;
      logic           sts;
   } rsp_t;

   logic vld;
   logic rdy;
   req_t req;
   rsp_t rsp;

   modport man (output vld, req, input rdy, rsp);
   modport sub (input vld, req, output rdy, rsp);

endinterface

// File: rtl/tcb_full_lib_logsize2byteena_dly_line.sv
// -----------------------------------------------------------------------------
// tcb_full_lib_logsize2byteena_dly_line
//
// Free-running shift register of DLY entries of type T. It never stalls,
// matching the fixed response latency of TCB.
//   clk   clock
//   rst   asynchronous active-high reset, clears every stage to '0
//   din   entry loaded into stage 0 every clock
//   dout  last stage (or din itself when DLY == 0)
// -----------------------------------------------------------------------------
module tcb_full_lib_logsize2byteena_dly_line #(
   parameter type         T   = logic,
   parameter int unsigned DLY = 1
) (
   input  logic clk,
   input  logic rst,
   input  T     din,
   output T     dout
);

   if (DLY == 0) begin : g_wire
      assign dout = din;
   end else begin : g_reg
      T stg [DLY];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int unsigned k = 0; k < DLY; k++) stg[k] <= '0;
         end else begin
            stg[0] <= din;
            for (int unsigned k = 1; k < DLY; k++) stg[k] <= stg[k-1];
         end
      end

      assign dout = stg[DLY-1];
   end

endmodule

// File: rtl/tcb_full_lib_logsize2byteena.sv
// -----------------------------------------------------------------------------
// tcb_full_lib_logsize2byteena
//
// Adapts a log-size TCB-Full manager to a byte-enable subordinate.
//   clk  clock (single domain for both sides)
//   rst  asynchronous active-high reset
//   sub  upstream log-size manager connects here
//   man  downstream byte-enable subordinate (memory controller)
//
// Request path is combinational: write data is rotated into byte lanes and a
// wrapping byte-enable mask is built from the address offset and size. The
// mask wraps past the top lane; the downstream controller uses the next word
// address for those lanes.
// Response path tracks {trn, wen, off, siz, uns} of every cycle through a
// DLY-deep delay line and uses the last stage to rotate read data back to
// lane 0 and zero/sign-extend it. Slots without a read transfer return '0.
// Supports buses of up to TCB_MAX_BYT byte lanes.
// -----------------------------------------------------------------------------
module tcb_full_lib_logsize2byteena
   import tcb_full_lib_logsize2byteena_pkg::*;
#(
   parameter type  cfg_t = tcb_cfg_t,
   parameter cfg_t CFG   = TCB_CFG_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   tcb_full_lib_logsize2byteena_if.sub     sub,
   tcb_full_lib_logsize2byteena_if.man     man
);

   localparam int unsigned DAT = CFG.BUS.DAT;
   localparam int unsigned BYT = DAT / 8;
   localparam int unsigned MAX = $clog2(BYT);
   localparam int unsigned DLY = CFG.HSK.DLY;

   localparam logic [TCB_OFF_W-1:0] OFF_MSK = TCB_OFF_W'(BYT - 1);

   // ---------------------------------------------------------------------------
   // Request path
   // ---------------------------------------------------------------------------
   logic [TCB_OFF_W-1:0]   req_off;
   logic [TCB_MAX_BYT-1:0] byt_full;
   logic [TCB_MAX_DAT-1:0] wdt_rot;
   logic [TCB_MAX_DAT-1:0] wdt_msk;

   assign req_off = TCB_OFF_W'(sub.req.adr) & OFF_MSK;

   always_comb begin
      byt_full = tcb_byt_mask(req_off, sub.req.siz, MAX);
      wdt_rot  = tcb_rot_left(TCB_MAX_DAT'(sub.req.wdt), req_off, MAX);
      // Lanes outside the mask carry unrelated bytes after rotation; zero them.
      wdt_msk  = '0;
      for (int unsigned b = 0; b < TCB_MAX_BYT; b++) begin
         wdt_msk[8*b +: 8] = wdt_rot[8*b +: 8] & {8{byt_full[b]}};
      end
   end

   assign man.vld     = sub.vld;
   assign sub.rdy     = man.rdy;
   assign man.req.wen = sub.req.wen;
   assign man.req.adr = sub.req.adr;
   assign man.req.siz = sub.req.siz;
   assign man.req.uns = sub.req.uns;
   assign man.req.byt = byt_full[BYT-1:0];
   assign man.req.wdt = wdt_msk[DAT-1:0];

   // Byte enables from the manager have no meaning in log-size mode.
   logic unused_sub_byt;
   assign unused_sub_byt = ^sub.req.byt;

   // ---------------------------------------------------------------------------
   // Response tracking
   // ---------------------------------------------------------------------------
   tcb_dly_t dly_in;
   tcb_dly_t dly_out;

   always_comb begin
      dly_in     = '0;
      dly_in.trn = sub.vld & man.rdy;
      dly_in.wen = sub.req.wen;
      dly_in.off = req_off;
      dly_in.siz = sub.req.siz;
      dly_in.uns = sub.req.uns;
   end

   tcb_full_lib_logsize2byteena_dly_line #(
      .T   (tcb_dly_t),
      .DLY (DLY)
   ) u_dly_line (
      .clk  (clk),
      .rst  (rst),
      .din  (dly_in),
      .dout (dly_out)
   );

   // ---------------------------------------------------------------------------
   // Response decode
   // ---------------------------------------------------------------------------
   logic [TCB_MAX_DAT-1:0] rdt_rot;
   logic [DAT-1:0]         rdt_raw;
   logic [DAT-1:0]         rdt_ext;
   logic                   rsp_msb;
   logic [7:0]             rsp_fill;
   int unsigned            rsp_len;

   always_comb begin
      rdt_rot  = tcb_rot_right(TCB_MAX_DAT'(man.rsp.rdt), dly_out.off, MAX);
      rdt_raw  = rdt_rot[DAT-1:0];
      rsp_len  = 32'd1 << dly_out.siz;
      // Sign bit is the MSB of the last byte actually transferred.
      rsp_msb  = 1'b0;
      for (int unsigned i = 0; i < BYT; i++) begin
         if (i + 1 == rsp_len) rsp_msb = rdt_raw[8*i+7];
      end
      rsp_fill = dly_out.uns ? 8'h00 : {8{rsp_msb}};
      rdt_ext  = '0;
      for (int unsigned i = 0; i < BYT; i++) begin
         rdt_ext[8*i +: 8] = (i < rsp_len) ? rdt_raw[8*i +: 8] : rsp_fill;
      end
   end

   assign sub.rsp.rdt = (dly_out.trn & ~dly_out.wen) ? rdt_ext : '0;
   assign sub.rsp.sts = man.rsp.sts;

   // A log-size wider than the bus cannot be expressed as byte enables.
   siz_legal_a : assert property (@(posedge clk) disable iff (rst)
      sub.vld |-> (32'(sub.req.siz) <= MAX));

endmodule

// File: tb/tb_tcb_full_lib_logsize2byteena.sv
// -----------------------------------------------------------------------------
// tb_tcb_full_lib_logsize2byteena
//
// 32-bit bus, one-cycle response delay. Directed vectors with literal
// expectations, followed by randomized traffic checked every cycle against
// an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_tcb_full_lib_logsize2byteena;
   import tcb_full_lib_logsize2byteena_pkg::*;

   localparam tcb_cfg_t CFG    = '{BUS: '{ADR: 32, DAT: 32}, HSK: '{DLY: 1}};
   localparam int       TB_DLY = 1;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   tcb_full_lib_logsize2byteena_if #(.cfg_t(tcb_cfg_t), .CFG(CFG)) tcb_sub ();
   tcb_full_lib_logsize2byteena_if #(.cfg_t(tcb_cfg_t), .CFG(CFG)) tcb_man ();

   tcb_full_lib_logsize2byteena #(
      .cfg_t (tcb_cfg_t),
      .CFG   (CFG)
   ) dut (
      .clk (clk),
      .rst (rst),
      .sub (tcb_sub),
      .man (tcb_man)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   typedef struct {
      bit          trn;
      bit          wen;
      int unsigned off;
      int unsigned siz;
      bit          uns;
   } ent_t;

   ent_t pipe [TB_DLY];

   function automatic int unsigned nbytes(input int unsigned siz);
      return (siz > 2) ? 4 : (1 << siz);
   endfunction

   function automatic logic [3:0] m_byt(input int unsigned adr, input int unsigned siz);
      int unsigned m = 0;
      for (int unsigned i = 0; i < nbytes(siz); i++) m |= 1 << ((adr + i) % 4);
      return 4'(m);
   endfunction

   function automatic logic [31:0] m_wdt(input int unsigned adr, input int unsigned siz,
                                         input logic [31:0] wdt);
      logic [31:0] r = 0;
      for (int unsigned i = 0; i < nbytes(siz); i++)
         r |= ((wdt >> (8 * i)) & 32'hFF) << (8 * ((adr + i) % 4));
      return r;
   endfunction

   function automatic logic [31:0] m_rdt(input ent_t e, input logic [31:0] rdt);
      logic [31:0] r = 0;
      logic [31:0] b = 0;
      int unsigned n;
      if (!e.trn || e.wen) return 32'h0;
      n = nbytes(e.siz);
      for (int unsigned i = 0; i < n; i++) begin
         b = (rdt >> (8 * ((e.off + i) % 4))) & 32'hFF;
         r |= b << (8 * i);
      end
      if (!e.uns && n < 4 && b[7]) r |= 32'hFFFF_FFFF << (8 * n);
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < TB_DLY; k++) pipe[k] <= '{0, 0, 0, 0, 0};
      end else begin
         pipe[0] <= '{tcb_sub.vld && tcb_man.rdy, tcb_sub.req.wen,
                      32'(tcb_sub.req.adr) % 4, 32'(tcb_sub.req.siz), tcb_sub.req.uns};
         for (int k = 1; k < TB_DLY; k++) pipe[k] <= pipe[k-1];
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      chk("man_vld", 64'(tcb_man.vld), 64'(tcb_sub.vld));
      chk("sub_rdy", 64'(tcb_sub.rdy), 64'(tcb_man.rdy));
      chk("man_wen", 64'(tcb_man.req.wen), 64'(tcb_sub.req.wen));
      chk("man_adr", 64'(tcb_man.req.adr), 64'(tcb_sub.req.adr));
      chk("man_byt", 64'(tcb_man.req.byt),
          64'(m_byt(32'(tcb_sub.req.adr), 32'(tcb_sub.req.siz))));
      chk("man_wdt", 64'(tcb_man.req.wdt),
          64'(m_wdt(32'(tcb_sub.req.adr), 32'(tcb_sub.req.siz), tcb_sub.req.wdt)));
      chk("sub_rdt", 64'(tcb_sub.rsp.rdt), 64'(m_rdt(pipe[TB_DLY-1], tcb_man.rsp.rdt)));
      chk("sub_sts", 64'(tcb_sub.rsp.sts), 64'(tcb_man.rsp.sts));
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   task automatic set_req(input logic vld, input logic wen, input logic [31:0] adr,
                          input logic [2:0] siz, input logic uns, input logic [31:0] wdt);
      tcb_sub.vld     = vld;
      tcb_sub.req.wen = wen;
      tcb_sub.req.adr = adr;
      tcb_sub.req.siz = siz;
      tcb_sub.req.uns = uns;
      tcb_sub.req.byt = '0;
      tcb_sub.req.wdt = wdt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic rd_vld;
      set_req(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
      tcb_man.rdy     = 1'b1;
      tcb_man.rsp.rdt = 32'h0;
      tcb_man.rsp.sts = 1'b0;
      #1 rst = 1'b1;
      tcb_man.rsp.rdt = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("reset_rdt", 64'(tcb_sub.rsp.rdt), 64'h0);
      tick();
      rst = 1'b0;

      // Byte write at offset 3.
      set_req(1'b1, 1'b1, 32'h1003, 3'd0, 1'b0, 32'h0000_00A5);
      @(negedge clk);
      chk("wr_byte_byt", 64'(tcb_man.req.byt), 64'b1000);
      chk("wr_byte_wdt", 64'(tcb_man.req.wdt), 64'hA500_0000);
      tick();

      // Misaligned half write wraps into lane 0.
      set_req(1'b1, 1'b1, 32'h1003, 3'd1, 1'b0, 32'h0000_BEEF);
      @(negedge clk);
      chk("wr_half_byt", 64'(tcb_man.req.byt), 64'b1001);
      chk("wr_half_wdt", 64'(tcb_man.req.wdt), 64'hEF00_00BE);
      tick();

      // Signed byte read.
      set_req(1'b1, 1'b0, 32'h2, 3'd0, 1'b0, 32'h0);
      tick();
      set_req(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
      tcb_man.rsp.rdt = 32'h0080_0000;
      @(negedge clk);
      chk("rd_byte_s", 64'(tcb_sub.rsp.rdt), 64'hFFFF_FF80);
      tick();

      // Unsigned byte read.
      set_req(1'b1, 1'b0, 32'h2, 3'd0, 1'b1, 32'h0);
      tick();
      set_req(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
      @(negedge clk);
      chk("rd_byte_u", 64'(tcb_sub.rsp.rdt), 64'h0000_0080);
      tick();

      // Misaligned word read.
      set_req(1'b1, 1'b0, 32'h1, 3'd2, 1'b0, 32'h0);
      tick();
      set_req(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
      tcb_man.rsp.rdt = 32'h4433_2211;
      @(negedge clk);
      chk("rd_word_mis", 64'(tcb_sub.rsp.rdt), 64'h1144_3322);
      tick();

      // Back-to-back reads with a stall on the second cycle.
      set_req(1'b1, 1'b0, 32'h0, 3'd2, 1'b1, 32'h0);
      tick();
      set_req(1'b1, 1'b0, 32'h1, 3'd2, 1'b1, 32'h0);
      tcb_man.rdy = 1'b0;
      @(negedge clk);
      chk("b2b_rsp0", 64'(tcb_sub.rsp.rdt), 64'h4433_2211);
      tick();
      tcb_man.rdy = 1'b1;
      @(negedge clk);
      chk("b2b_stall_gap", 64'(tcb_sub.rsp.rdt), 64'h0);
      tick();
      set_req(1'b1, 1'b0, 32'h2, 3'd2, 1'b1, 32'h0);
      @(negedge clk);
      chk("b2b_rsp1", 64'(tcb_sub.rsp.rdt), 64'h1144_3322);
      tick();
      set_req(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
      @(negedge clk);
      chk("b2b_rsp2", 64'(tcb_sub.rsp.rdt), 64'h2211_4433);
      tick();

      // Reset right after a read transfer drops its response.
      set_req(1'b1, 1'b0, 32'h0, 3'd2, 1'b1, 32'h0);
      tick();
      rst = 1'b1;
      set_req(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
      tcb_man.rsp.rdt = 32'hCAFE_F00D;
      @(negedge clk);
      chk("rst_drop", 64'(tcb_sub.rsp.rdt), 64'h0);
      tick();
      rst = 1'b0;
      set_req(1'b1, 1'b0, 32'h0, 3'd2, 1'b1, 32'h0);
      tick();
      set_req(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
      @(negedge clk);
      chk("rst_after", 64'(tcb_sub.rsp.rdt), 64'hCAFE_F00D);
      tick();

      // Oversized request (idle, so no assertion): all lanes enabled.
      set_req(1'b0, 1'b1, 32'h5, 3'd3, 1'b0, 32'h1122_3344);
      @(negedge clk);
      chk("ovr_byt", 64'(tcb_man.req.byt), 64'hF);
      chk("ovr_wdt", 64'(tcb_man.req.wdt), 64'h2233_4411);
      tick();

      // Randomized traffic; the compare process checks every cycle.
      for (int c = 0; c < 3000; c++) begin
         rd_vld = 1'($urandom_range(0, 3) != 0);
         set_req(rd_vld, 1'($urandom), $urandom,
                 3'(rd_vld ? $urandom_range(0, 2) : $urandom_range(0, 3)),
                 1'($urandom), $urandom);
         tcb_man.rdy     = 1'($urandom_range(0, 3) != 0);
         tcb_man.rsp.rdt = $urandom;
         tcb_man.rsp.sts = 1'($urandom);
         rst             = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      set_req(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
